// File: rtl/montexp_pkg.sv
// Shared definitions for the modular-exponentiation sequencer.
//   N_DEF / EW_DEF : default operand width and exponent-length field width
//   state_t        : sequencer states
//   opsel_t        : which operand pair is presented to the multiplier
//   sel_of()       : maps a state to the operand pair it needs
package montexp_pkg;

    localparam int N_DEF  = 1024;
    localparam int EW_DEF = 11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SQ_START,
        S_SQ_WAIT,
        S_MUL_START,
        S_MUL_WAIT,
        S_POST_START,
        S_POST_WAIT
    } state_t;

    typedef enum logic [1:0] {
        SEL_SQ,
        SEL_MUL,
        SEL_POST
    } opsel_t;

    // IDLE reuses the square selection so both operands read the
    // accumulator, which makes every operand port zero out of reset.
    function automatic opsel_t sel_of(input state_t s);
        opsel_t sel;
        case (s)
            S_MUL_START, S_MUL_WAIT:   sel = SEL_MUL;
            S_POST_START, S_POST_WAIT: sel = SEL_POST;
            default:                   sel = SEL_SQ;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/montexp_escan.sv
// Exponent scanner: MSB-first shift register plus remaining-bit down-counter.
//   clk, resetn : clock, asynchronous active-low reset
//   load        : capture in_e left-aligned by len and set the counter to len
//   shift       : consume one exponent bit
//   in_e        : right-aligned exponent
//   len         : number of bits to scan, already clamped to 0..N
//   scan_bit    : exponent bit currently under the scan (MSB of the register)
//   last        : the current bit is the final one to be scanned
module montexp_escan
    import montexp_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int EW = EW_DEF
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          load,
    input  logic          shift,
    input  logic [N-1:0]  in_e,
    input  logic [EW-1:0] len,
    output logic          scan_bit,
    output logic          last
);

    logic [N-1:0]  e_q;
    logic [EW-1:0] cnt_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            e_q   <= '0;
            cnt_q <= '0;
        end else if (load) begin
            // Left-align so the first scanned bit sits at the MSB; len = 0
            // shifts everything out, which is harmless as nothing is scanned.
            e_q   <= in_e << (EW'(N) - len);
            cnt_q <= len;
        end else if (shift) begin
            e_q   <= e_q << 1;
            cnt_q <= cnt_q - EW'(1);
        end
    end

    assign scan_bit = e_q[N-1];
    assign last     = (cnt_q == EW'(1));

endmodule

// File: rtl/montexp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving an external
// Montgomery multiplier; a final multiply-by-1 leaves the Montgomery domain.
//   clk, resetn          : clock, asynchronous active-low reset
//   start                : one-cycle request, honoured only in IDLE
//   in_x, in_r, in_m     : base (Montgomery form), R mod M, odd modulus
//   in_e, e_len          : right-aligned exponent and number of bits to scan
//   mm_start, mm_a/b/m   : multiplier start pulse and operands
//   mm_result, mm_done   : multiplier result and completion pulse
//   result, busy, done   : final value, operation in progress, completion pulse
//
// state        | meaning
// -------------+-----------------------------------------------
// S_IDLE       | waiting for start
// S_SQ_START   | pulse mm_start for A*A
// S_SQ_WAIT    | wait for A*A, then multiply or advance the scan
// S_MUL_START  | pulse mm_start for A*X
// S_MUL_WAIT   | wait for A*X, then advance the scan
// S_POST_START | pulse mm_start for A*1 (leave Montgomery domain)
// S_POST_WAIT  | wait for A*1, publish result and return to idle
module montexp_ctrl
    import montexp_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int EW = EW_DEF
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic [N-1:0]  in_x,
    input  logic [N-1:0]  in_r,
    input  logic [N-1:0]  in_m,
    input  logic [N-1:0]  in_e,
    input  logic [EW-1:0] e_len,
    output logic          mm_start,
    output logic [N-1:0]  mm_a,
    output logic [N-1:0]  mm_b,
    output logic [N-1:0]  mm_m,
    input  logic [N-1:0]  mm_result,
    input  logic          mm_done,
    output logic [N-1:0]  result,
    output logic          busy,
    output logic          done
);

    state_t        state_q, state_d;
    logic [N-1:0]  a_q, x_q, m_q, result_q;
    logic          done_q;
    logic [EW-1:0] len_c;
    logic          load, shift, a_ld, res_ld;
    logic          scan_bit, last;
    opsel_t        sel;

    assign len_c = (e_len > EW'(N)) ? EW'(N) : e_len;

    montexp_escan #(.N(N), .EW(EW)) u_escan (
        .clk      (clk),
        .resetn   (resetn),
        .load     (load),
        .shift    (shift),
        .in_e     (in_e),
        .len      (len_c),
        .scan_bit (scan_bit),
        .last     (last)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mm_start = 1'b0;
        load     = 1'b0;
        shift    = 1'b0;
        a_ld     = 1'b0;
        res_ld   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = (len_c != '0) ? S_SQ_START : S_POST_START;
                end
            end
            S_SQ_START: begin
                mm_start = 1'b1;
                state_d  = S_SQ_WAIT;
            end
            S_SQ_WAIT: begin
                if (mm_done) begin
                    a_ld = 1'b1;
                    if (scan_bit) begin
                        state_d = S_MUL_START;
                    end else begin
                        shift   = 1'b1;
                        state_d = last ? S_POST_START : S_SQ_START;
                    end
                end
            end
            S_MUL_START: begin
                mm_start = 1'b1;
                state_d  = S_MUL_WAIT;
            end
            S_MUL_WAIT: begin
                if (mm_done) begin
                    a_ld    = 1'b1;
                    shift   = 1'b1;
                    state_d = last ? S_POST_START : S_SQ_START;
                end
            end
            S_POST_START: begin
                mm_start = 1'b1;
                state_d  = S_POST_WAIT;
            end
            S_POST_WAIT: begin
                if (mm_done) begin
                    res_ld  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_q      <= '0;
            x_q      <= '0;
            m_q      <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= res_ld;
            if (load) begin
                a_q <= in_r;
                x_q <= in_x;
                m_q <= in_m;
            end else if (a_ld) begin
                a_q <= mm_result;
            end
            if (res_ld) begin
                result_q <= mm_result;
            end
        end
    end

    // Operands are pure functions of registers that only move on mm_done,
    // so they stay stable for the whole wait.
    always_comb begin
        sel  = sel_of(state_q);
        mm_b = a_q;
        case (sel)
            SEL_MUL:  mm_b = x_q;
            SEL_POST: mm_b = N'(1);
            default:  mm_b = a_q;
        endcase
    end

    assign mm_a   = a_q;
    assign mm_m   = m_q;
    assign result = result_q;
    assign done   = done_q;
    assign busy   = (state_q != S_IDLE);

endmodule
